rr_access_scheduler: RTL and testbench
======================================

# rr_access_scheduler

Time-sliced round-robin scheduler that shares one single-owner resource (e.g. a shared bus or memory port) among N requesters. It builds on the team's round-robin arbitration with an ownership handshake, a per-grant cycle quota (quantum) with forced preemption, and a mandatory one-cycle turnaround gap between owners. It sits between the requesting engines and the shared resource's select/mux logic.

## Interface
- N, default 4: number of requesters; minimum 2.
- QUANTUM, default 8: maximum consecutive cycles one grant may stay high; minimum 1.
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  when low, no new grant is issued; a current owner is not affected.
- req  input  N  per-requester request; held high for as long as ownership is wanted.
- grant  output  N  registered one-hot grant; all zero when nobody owns the resource.
- busy  output  1  registered; equals |grant.
- owner_id  output  $clog2(N)  registered index of the current or most recent owner.
- expired  output  1  registered one-cycle pulse when a grant is removed by quantum expiry.

## Operation
- Registered state: FSM {IDLE, OWN, GAP}, last-owner pointer `last`, quantum counter `cnt` of width $clog2(QUANTUM+1).
- Arbitration (IDLE, or the last cycle of GAP): the winner is the first index i with req[i]=1, searching last+1, last+2, … wrapping modulo N, and ending with `last` itself. A winner is taken only if enable=1 and |req=1.
- IDLE: on an edge with a winner, grant <= onehot(winner), owner_id <= winner, last <= winner, cnt <= 1, go to OWN. Otherwise stay in IDLE with grant=0.
- OWN, evaluated at each edge:
  - req[owner]=0: release. grant <= 0, go to GAP, expired stays 0.
  - Otherwise, if cnt==QUANTUM: preempt. grant <= 0, expired <= 1, go to GAP.
  - Otherwise: hold grant, cnt <= cnt+1.
  - If the release and quantum end fall on the same edge, the release takes precedence and expired stays 0.
- GAP: lasts exactly one cycle with grant=0, and expired falls back to 0 at its end. At the edge leaving GAP, the FSM arbitrates as in IDLE: with a winner it goes straight to OWN with the new grant, otherwise to IDLE.
- A preempted requester that still has req high competes normally. Because it is now `last`, it has the lowest priority and wins again only if nobody else requests.
- Requests that drop before being granted leave no memory behind.
- enable is sampled only at arbitration edges.
- owner_id is not cleared on release; it holds its value until the next grant.
- Reset (asynchronous, at any point including mid-ownership): grant=0, busy=0, expired=0, owner_id=0, last=N-1 (so requester 0 has first priority), cnt=0, state IDLE.

## Timing
- Request-to-grant latency from IDLE is 1 cycle: req sampled high at edge k gives grant high after edge k.
- Grant pulse length:
  - With a continuous request, grant is high for exactly QUANTUM cycles.
  - If req drops while grant is high, grant falls at the first edge that samples req=0.
- Turnaround: at least one full cycle with grant=0 between any two grants, including a re-grant to the same requester.
- Worst-case wait for a continuously requesting input: (N-1)*(QUANTUM+1) cycles after the current grant ends.
- expired is high during the first GAP cycle only.
- grant is never multi-hot, including across reset release.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then req=4'b0001 at edge 1: grant=0001 after edge 1, owner_id=0. req dropped at edge 4: grant=0 after edge 4, expired=0, one GAP cycle, then IDLE.
- req=4'b1111 held, QUANTUM=8: grants rotate 0001→0010→0100→1000→0001. Each grant is high 8 cycles, followed by one gap cycle with expired=1.
- Single requester req=4'b0100 held: grant=0100 for 8 cycles, 1 gap cycle with expired=1, then grant=0100 again for another 8 cycles.
- Release on quantum edge: req[1] drops exactly at the edge where cnt==8. Required: grant=0, expired=0.
- enable=0 while req=4'b0011 in IDLE: no grant. enable raised: grant=0001 at the next edge. enable dropped mid-ownership: the owner keeps its grant until release or expiry, then no new grant.
- reset_n asserted mid-grant (grant=1000, cnt=5): grant/busy/expired clear immediately without a clock. After release with req=4'b1001: grant=0001 first.

Source files
------------

// File: rtl/rr_access_scheduler.sv
// Time-sliced round-robin scheduler for one single-owner resource.
// A grant lasts until the owner drops its request or QUANTUM cycles elapse,
// after which the resource is idle for one turnaround cycle before the next
// owner is chosen. Arbitration starts just after the most recent owner, so
// the previous owner always has the lowest priority.
module rr_access_scheduler #(
    parameter int N       = 4,
    parameter int QUANTUM = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner_id,
    output logic                 expired
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(QUANTUM + 1);
    localparam logic [CW-1:0] QMAX = CW'(QUANTUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_GAP
    } state_e;

    state_e          state_q;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [N-1:0]    grant_q;
    logic            busy_q;
    logic [IW-1:0]   owner_q;
    logic            expired_q;

    logic            win_valid;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [N-1:0]    win_onehot;
    logic            arb_take;

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign owner_id = owner_q;
    assign expired  = expired_q;

    assign cnt_d    = cnt_q + CW'(1);
    assign arb_take = enable & win_valid;

    // Round-robin search: scan from last+N down to last+1 so the closest
    // requester after the previous owner overwrites every farther one.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        win_valid  = 1'b0;
        win_idx    = last_q;
        cand       = last_q;
        win_onehot = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % N);
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot[win_idx] = 1'b1;
    end

    // Ownership FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples values from before the edge, independent of
        // statement order.
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            last_q    <= IW'(N - 1);
            cnt_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_GAP: begin
                    expired_q <= 1'b0;
                    if (arb_take) begin
                        grant_q <= win_onehot;
                        busy_q  <= 1'b1;
                        owner_q <= win_idx;
                        last_q  <= win_idx;
                        cnt_q   <= CW'(1);
                        state_q <= ST_OWN;
                    end else begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (!req[owner_q]) begin
                        // Voluntary release wins over a coinciding quantum end.
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        expired_q <= 1'b0;
                        state_q   <= ST_GAP;
                    end else if (cnt_q == QMAX) begin
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        expired_q <= 1'b1;
                        state_q   <= ST_GAP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    expired_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_access_scheduler.sv
// Bench for rr_access_scheduler: directed scenarios plus randomized traffic,
// all compared against an ownership-level model of the scheduler.
module tb_rr_access_scheduler;

    localparam int N = 4;
    localparam int Q = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         busy;
    logic [1:0]   owner_id;
    logic         expired;

    int vectors     = 0;
    int miscompares = 0;

    // Model: who owns the resource (-1 = nobody), how long they have held it,
    // most recent owner, and whether the last removal was a quantum expiry.
    int m_owner;
    int m_held;
    int m_last;
    int m_id;
    bit m_exp;

    rr_access_scheduler #(.N(N), .QUANTUM(Q)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .req      (req),
        .grant    (grant),
        .busy     (busy),
        .owner_id (owner_id),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = N - 1;
        m_id    = 0;
        m_exp   = 1'b0;
    endtask

    // One clock edge of the model. A cycle with no owner (idle or the
    // turnaround cycle) is always an arbitration opportunity.
    task automatic model_edge();
        bit found;
        int i;
        if (m_owner >= 0) begin
            if (!req[m_owner]) begin
                m_owner = -1;
                m_exp   = 1'b0;
            end else if (m_held == Q) begin
                m_owner = -1;
                m_exp   = 1'b1;
            end else begin
                m_held++;
                m_exp = 1'b0;
            end
        end else begin
            m_exp = 1'b0;
            found = 1'b0;
            if (enable) begin
                for (int off = 1; off <= N; off++) begin
                    i = (m_last + off) % N;
                    if (!found && req[i]) begin
                        found   = 1'b1;
                        m_owner = i;
                        m_last  = i;
                        m_id    = i;
                        m_held  = 1;
                    end
                end
            end
        end
    endtask

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        req     = '0;
        model_reset();
        #12;
        vectors += 4;
        if (grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b want 0000", grant); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (expired !== 1'b0) begin miscompares++; $display("FAIL reset_expired: got %b want 0", expired); end
        if (owner_id !== 2'd0) begin miscompares++; $display("FAIL reset_owner_id: got %0d want 0", owner_id); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_release();
        req = 4'b0001;
        tick();
        vectors += 2;
        if (grant !== 4'b0001) begin miscompares++; $display("FAIL release_first_grant: got %b want 0001", grant); end
        if (owner_id !== 2'd0) begin miscompares++; $display("FAIL release_owner_id: got %0d want 0", owner_id); end
        for (int c = 0; c < 6; c++) begin
            if (c == 2) req = 4'b0000;
            tick();
            vectors += 2;
            if (grant !== m_grant()) begin miscompares++; $display("FAIL release_grant c%0d: got %b want %b", c, grant, m_grant()); end
            if (expired !== m_exp) begin miscompares++; $display("FAIL release_expired c%0d: got %b want %b", c, expired, m_exp); end
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] prev;
        int           changes;
        req     = 4'b1111;
        changes = 0;
        prev    = grant;
        for (int c = 0; c < 5 * (Q + 1) + 2; c++) begin
            tick();
            vectors += 3;
            if (grant !== m_grant()) begin miscompares++; $display("FAIL rotation_grant c%0d: got %b want %b", c, grant, m_grant()); end
            if (expired !== m_exp) begin miscompares++; $display("FAIL rotation_expired c%0d: got %b want %b", c, expired, m_exp); end
            if (busy !== (m_owner >= 0)) begin miscompares++; $display("FAIL rotation_busy c%0d: got %b want %b", c, busy, m_owner >= 0); end
            if (grant != prev && grant != '0) changes++;
            prev = grant;
        end
        vectors++;
        if (changes < 5) begin miscompares++; $display("FAIL rotation_count: got %0d grants want at least 5", changes); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_single_hold();
        int high;
        req  = 4'b0100;
        high = 0;
        for (int c = 0; c < 2 * (Q + 1) + 1; c++) begin
            tick();
            vectors += 2;
            if (grant !== m_grant()) begin miscompares++; $display("FAIL hold_grant c%0d: got %b want %b", c, grant, m_grant()); end
            if (expired !== m_exp) begin miscompares++; $display("FAIL hold_expired c%0d: got %b want %b", c, expired, m_exp); end
            if (c < Q + 1 && grant == 4'b0100) high++;
        end
        vectors++;
        if (high !== Q) begin miscompares++; $display("FAIL hold_length: got %0d cycles want %0d", high, Q); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_release_on_quantum();
        req = 4'b0010;
        tick();
        for (int c = 0; c < Q - 1; c++) tick();
        vectors++;
        if (grant !== 4'b0010) begin miscompares++; $display("FAIL rq_pre_grant: got %b want 0010", grant); end
        req = 4'b0000;
        tick();
        vectors += 2;
        if (grant !== 4'b0000) begin miscompares++; $display("FAIL rq_grant: got %b want 0000", grant); end
        if (expired !== 1'b0) begin miscompares++; $display("FAIL rq_expired: got %b want 0", expired); end
        tick();
        tick();
    endtask

    task automatic test_enable();
        enable = 1'b0;
        req    = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (grant !== 4'b0000) begin miscompares++; $display("FAIL en_low_grant c%0d: got %b want 0000", c, grant); end
        end
        enable = 1'b1;
        for (int c = 0; c < Q + 6; c++) begin
            tick();
            if (c == 1) enable = 1'b0;
            vectors += 2;
            if (grant !== m_grant()) begin miscompares++; $display("FAIL en_grant c%0d: got %b want %b", c, grant, m_grant()); end
            if (expired !== m_exp) begin miscompares++; $display("FAIL en_expired c%0d: got %b want %b", c, expired, m_exp); end
        end
        enable = 1'b1;
        req    = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_grant();
        req = 4'b1000;
        for (int c = 0; c < 5; c++) tick();
        vectors++;
        if (grant !== 4'b1000) begin miscompares++; $display("FAIL rm_pre_grant: got %b want 1000", grant); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        vectors += 4;
        if (grant !== 4'b0000) begin miscompares++; $display("FAIL rm_grant: got %b want 0000", grant); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b want 0", busy); end
        if (expired !== 1'b0) begin miscompares++; $display("FAIL rm_expired: got %b want 0", expired); end
        if (owner_id !== 2'd0) begin miscompares++; $display("FAIL rm_owner_id: got %0d want 0", owner_id); end
        #1;
        reset_n = 1'b1;
        req     = 4'b1001;
        tick();
        vectors += 2;
        if (grant !== 4'b0001) begin miscompares++; $display("FAIL rm_regrant: got %b want 0001", grant); end
        if (grant !== m_grant()) begin miscompares++; $display("FAIL rm_model: got %b want %b", grant, m_grant()); end
        req = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            enable = ($urandom_range(0, 15) != 0);
            tick();
            vectors += 5;
            if (grant !== m_grant()) begin miscompares++; $display("FAIL rand_grant c%0d: got %b want %b", c, grant, m_grant()); end
            if (expired !== m_exp) begin miscompares++; $display("FAIL rand_expired c%0d: got %b want %b", c, expired, m_exp); end
            if (busy !== (m_owner >= 0)) begin miscompares++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_owner >= 0); end
            if (owner_id !== 2'(m_id)) begin miscompares++; $display("FAIL rand_owner_id c%0d: got %0d want %0d", c, owner_id, m_id); end
            if ($countones(grant) > 1) begin miscompares++; $display("FAIL rand_onehot c%0d: got %b want at most one bit", c, grant); end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_rotation();
        test_single_hold();
        test_release_on_quantum();
        test_enable();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
